// File: rtl/sevseg_scan_ctrl.sv
// Basys3 4-digit common-anode 7-segment scan controller with a double-buffered value,
// frame-aligned shadow update, dead-time blanking and leading-zero suppression.
module hex2sevseg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    // {CA,CB,CC,CD,CE,CF,CG}, active-low
    always_comb begin
        seg_o = 7'b1111111;
        unique case (hex_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
        endcase
    end
endmodule

module sevseg_scan_ctrl #(
    parameter int unsigned TICK_DIV  = 25000,
    parameter int unsigned BLANK_CYC = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_en_i,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy_o,
    output logic        frame_done_o
);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_v_q, pend_v_d;
    logic [15:0]   shd_val_q, shd_val_d;
    logic [3:0]    shd_dp_q, shd_dp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;

    logic          boundary;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic [15:0]   upper;
    logic          suppress;

    hex2sevseg u_dec (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    always_comb begin
        boundary = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
        nibble   = shd_val_q[{idx_q, 2'b00} +: 4];
        upper    = shd_val_q >> {idx_q, 2'b00};
        suppress = lz_en_i && (idx_q != 2'd0) && (upper == 16'h0000);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_v_d   = pend_v_q;
        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        // A load landing on the boundary bypasses the pending stage entirely.
        if (boundary && load_i) begin
            shd_val_d = value_i;
            shd_dp_d  = dp_i;
            pend_v_d  = 1'b0;
        end else if (boundary && pend_v_q) begin
            shd_val_d = pend_val_q;
            shd_dp_d  = pend_dp_q;
            pend_v_d  = 1'b0;
        end else if (load_i) begin
            pend_val_d = value_i;
            pend_dp_d  = dp_i;
            pend_v_d   = 1'b1;
        end

        an_d = '1;
        if (en_i && (cnt_q >= BLANK_END) && !suppress)
            an_d = ~(4'b0001 << idx_q);
        seg_d = dec_seg;
        dp_d  = ~shd_dp_q[idx_q];
        fd_d  = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_v_q   <= 1'b0;
            shd_val_q  <= '0;
            shd_dp_q   <= '0;
            an_q       <= '1;
            seg_q      <= '1;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            shd_val_q  <= shd_val_d;
            shd_dp_q   <= shd_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign busy_o       = pend_v_q;
    assign frame_done_o = fd_q;
endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl at TICK_DIV=8, BLANK_CYC=2.
module tb_sevseg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i, load_i, lz_en_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, busy_o, frame_done_o;

    int unsigned tests = 0;
    int unsigned failed = 0;

    sevseg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .load_i       (load_i),
        .value_i      (value_i),
        .dp_i         (dp_i),
        .lz_en_i      (lz_en_i),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge where frame_done_o is seen high (DUT then sits at cnt=0, idx=0).
    task automatic wait_frame(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (frame_done_o) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    // From a frame-start negedge, sample the middle of each digit's active phase.
    task automatic chk_frame(input string tag, input logic [27:0] seg_e,
                             input logic [15:0] an_e, input logic [3:0] dp_e);
        for (int d = 0; d < 4; d++) begin
            step(d == 0 ? 5 : 8);
            chk({tag, "_an", 8'(48 + d)}, {28'd0, an}, {28'd0, an_e[4*d +: 4]});
            chk({tag, "_seg", 8'(48 + d)}, {25'd0, seg}, {25'd0, seg_e[7*d +: 7]});
            chk({tag, "_dp", 8'(48 + d)}, {31'd0, dp}, {31'd0, dp_e[d]});
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        value_i = v;
        dp_i    = d;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
    endtask

    localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [6:0]  S0 = 7'b0000001;

    initial begin
        int unsigned fd_cnt;
        logic [3:0]  an_exp;
        rst_n = 1'b0; en_i = 1'b1; load_i = 1'b0; lz_en_i = 1'b0;
        value_i = '0; dp_i = '0;

        // 1. reset state and first frame
        step(3);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_fd", {31'd0, frame_done_o}, 32'd0);
        rst_n = 1'b1;
        step(5);
        chk("first_an0", {28'd0, an}, 32'hE);
        chk("first_seg0", {25'd0, seg}, {25'd0, S0});

        // 2. load 1234 with dp on digit 1
        step(2);
        load(16'h1234, 4'b0010);
        chk("busy_rise", {31'd0, busy_o}, 32'd1);
        wait_frame("wait_1234");
        chk("busy_fall", {31'd0, busy_o}, 32'd0);
        chk_frame("f1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, AN_ALL, 4'b1101);

        // 3. dead time and frame period over one full frame
        wait_frame("wait_dead");
        fd_cnt = 0;
        for (int j = 1; j <= 32; j++) begin
            step(1);
            if (frame_done_o) fd_cnt++;
            an_exp = ((j - 1) % 8 < 2) ? 4'b1111 : ~(4'b0001 << ((j - 1) / 8));
            chk("dead_an", {28'd0, an}, {28'd0, an_exp});
        end
        chk("fd_count", fd_cnt, 32'd1);
        chk("fd_end", {31'd0, frame_done_o}, 32'd1);

        // 4. leading-zero suppression
        lz_en_i = 1'b1;
        step(3);
        load(16'h0050, 4'b0000);
        wait_frame("wait_0050");
        chk_frame("lz50", {S0, S0, 7'b0100100, S0},
                  {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 4'b1111);
        load(16'h0000, 4'b0000);
        wait_frame("wait_0000");
        chk_frame("lz00", {S0, S0, S0, S0},
                  {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1111);
        lz_en_i = 1'b0;

        // 5. last load wins, then a load on the boundary cycle itself
        step(3);
        load(16'h1111, 4'b0000);
        step(3);
        load(16'h2222, 4'b0000);
        wait_frame("wait_2222");
        chk_frame("l2222", {4{7'b0010010}}, AN_ALL, 4'b1111);
        step(2);   // now at j=31 of this frame: the boundary cycle
        value_i = 16'hABCD; dp_i = 4'b0000; load_i = 1'b1;
        step(1);
        load_i = 1'b0;
        chk("bnd_fd", {31'd0, frame_done_o}, 32'd1);
        chk("bnd_busy", {31'd0, busy_o}, 32'd0);
        chk_frame("lABCD", {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, AN_ALL, 4'b1111);

        // 6. enable off mid-slot, then asynchronous reset mid-slot
        wait_frame("wait_en");
        step(5);
        en_i = 1'b0;
        step(1);
        chk("en_off_an", {28'd0, an}, 32'hF);
        chk("en_off_seg", {25'd0, seg}, {25'd0, 7'b1000010});
        load(16'h9999, 4'b1111);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        en_i = 1'b1;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an", {28'd0, an}, 32'hF);
        chk("arst_seg", {25'd0, seg}, 32'h7F);
        chk("arst_dp", {31'd0, dp}, 32'd1);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_fd", {31'd0, frame_done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_frame("post_rst", {S0, S0, S0, S0}, AN_ALL, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
